axis_rr_tx_arbiter: RTL and testbench

AXIS_RR_TX_ARBITER -- requirements
Module: axis_rr_tx_arbiter

---
 rtl/axis_rr_tx_arbiter_pkg.sv | 11 +
 rtl/axis_reg_slice.sv | 55 +++++
 rtl/axis_rr_tx_arbiter.sv | 113 +++++++++++
 tb/tb_axis_rr_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_tx_arbiter_pkg.sv
// Shared constants for the TX queue arbiter: FSM encoding and frame counter width.
package axis_rr_tx_arbiter_pkg;

  localparam int FRAME_CNT_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream register slice; ready depends only on occupancy, so no
// combinational path runs from m_tready back to s_tready.
module axis_reg_slice #(
  parameter int AXIS_WIDTH = 64,
  parameter int KEEP_WIDTH = AXIS_WIDTH/8
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [AXIS_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [AXIS_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  typedef struct packed {
    logic                  last;
    logic [KEEP_WIDTH-1:0] keep;
    logic [AXIS_WIDTH-1:0] data;
  } beat_t;

  beat_t      mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       push, pop;

  assign s_tready = (cnt != 2'd2);
  assign m_tvalid = (cnt != 2'd0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign {m_tlast, m_tkeep, m_tdata} = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      cnt    <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{last: s_tlast, keep: s_tkeep, data: s_tdata};
  end

endmodule

// File: rtl/axis_rr_tx_arbiter.sv
// Round-robin, frame-atomic arbiter merging NUM_PORTS AXI-Stream queues onto
// one MAC TX stream through a 2-entry register slice.
module axis_rr_tx_arbiter
  import axis_rr_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int AXIS_WIDTH = 64,
  parameter int KEEP_WIDTH = AXIS_WIDTH/8
) (
  input  logic                            clk_i,
  input  logic                            resetn_i,
  input  logic [NUM_PORTS*AXIS_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid_i,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast_i,
  output logic [NUM_PORTS-1:0]            s_axis_tready_o,
  output logic [AXIS_WIDTH-1:0]           m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep_o,
  output logic                            m_axis_tvalid_o,
  output logic                            m_axis_tlast_o,
  input  logic                            m_axis_tready_i,
  input  logic [NUM_PORTS-1:0]            port_enable_i,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic [FRAME_CNT_W-1:0]          frame_cnt_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][AXIS_WIDTH-1:0] tdata_v;
  logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0] tkeep_v;

  arb_state_t             state;
  logic [NUM_PORTS-1:0]   grant;
  logic [IDX_W-1:0]       grant_idx, last_grant, pick_idx;
  logic                   pick_found;
  logic [NUM_PORTS-1:0]   elig;
  logic                   in_valid, in_ready, in_last, accept;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  assign tdata_v = s_axis_tdata_i;
  assign tkeep_v = s_axis_tkeep_i;
  assign elig    = s_axis_tvalid_i & port_enable_i;

  // First eligible port strictly after the previous winner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!pick_found && elig[(int'(last_grant) + i) % NUM_PORTS]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      end
    end
  end

  // Enable is deliberately ignored once granted: a frame always runs to tlast.
  assign in_valid        = (state == FWD) && s_axis_tvalid_i[grant_idx];
  assign in_last         = s_axis_tlast_i[grant_idx];
  assign accept          = in_valid && in_ready;
  assign s_axis_tready_o = ((state == FWD) && in_ready) ? grant : '0;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_PORTS-1);
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          state     <= FWD;
          grant_idx <= pick_idx;
          grant     <= NUM_PORTS'(1) << pick_idx;
        end
        FWD: if (accept && in_last) begin
          state      <= IDLE;
          grant      <= '0;
          last_grant <= grant_idx;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i)
      frame_cnt <= '0;
    else if (m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o)
      frame_cnt <= frame_cnt + 1'b1;
  end

  assign grant_o     = grant;
  assign frame_cnt_o = frame_cnt;

  axis_reg_slice #(
    .AXIS_WIDTH(AXIS_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_slice (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .s_tdata  (tdata_v[grant_idx]),
    .s_tkeep  (tkeep_v[grant_idx]),
    .s_tlast  (in_last),
    .s_tvalid (in_valid),
    .s_tready (in_ready),
    .m_tdata  (m_axis_tdata_o),
    .m_tkeep  (m_axis_tkeep_o),
    .m_tlast  (m_axis_tlast_o),
    .m_tvalid (m_axis_tvalid_o),
    .m_tready (m_axis_tready_i)
  );

endmodule

// File: tb/tb_axis_rr_tx_arbiter.sv
// Directed bench for axis_rr_tx_arbiter: per-port source queues and an output
// capture queue feed a linear sequence of checked steps.
module tb_axis_rr_tx_arbiter;

  localparam int NP = 4;
  localparam int W  = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [W-1:0]  data;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NP*W-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP-1:0]   s_tvalid = '0, s_tlast = '0, port_en = '0;
  logic [NP-1:0]   s_tready, grant;
  logic [W-1:0]    m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast;
  logic            m_tready = 1'b1;
  logic [31:0]     frame_cnt;

  int    vectors = 0, miscompares = 0;
  beat_t q [NP][$];
  beat_t cap [$];
  int    cap_cyc [$];
  int    cyc = 0, rdy_base = 0, stall_err = 0;
  bit    rdy_mode = 1'b0, saw_bp = 1'b0, prev_stall = 1'b0;
  beat_t prev = '0;
  logic [NP-1:0] fire;

  always #5 clk = ~clk;

  axis_rr_tx_arbiter #(.NUM_PORTS(NP), .AXIS_WIDTH(W), .KEEP_WIDTH(KW)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep),
    .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast), .m_axis_tready_i(m_tready),
    .port_enable_i(port_en), .grant_o(grant), .frame_cnt_o(frame_cnt)
  );

  function automatic beat_t mk(input int p, input int f, input int b, input int n);
    beat_t x;
    x.last = (b == n-1);
    x.keep = x.last ? 8'h0F : 8'hFF;
    x.data = {8'hA5, 8'(p), 8'(f), 8'(b), 32'h0};
    return x;
  endfunction

  task automatic load(input int p, input int f, input int n);
    for (int b = 0; b < n; b++) q[p].push_back(mk(p, f, b, n));
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic edge_drive();
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int t = 0;
    while (cap.size() < n && t < 200) begin
      sample();
      t++;
    end
    chk(tag, 96'(cap.size()), 96'(n));
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_cyc.delete();
  endtask

  // Source queues and output monitor: sample handshakes at negedge, update drive after posedge.
  always begin
    @(negedge clk);
    fire = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      cap.push_back({m_tlast, m_tkeep, m_tdata});
      cap_cyc.push_back(cyc);
    end
    if (prev_stall && (!m_tvalid || {m_tlast, m_tkeep, m_tdata} !== prev)) stall_err++;
    prev_stall = m_tvalid && !m_tready;
    prev = {m_tlast, m_tkeep, m_tdata};
    if (grant[1] && s_tvalid[1] && !s_tready[1]) saw_bp = 1'b1;
    @(posedge clk);
    cyc++;
    #2;
    for (int k = 0; k < NP; k++) begin
      if (fire[k] && q[k].size() > 0) void'(q[k].pop_front());
      s_tvalid[k] = (q[k].size() > 0);
      if (q[k].size() > 0) begin
        s_tdata[k*W +: W]   = q[k][0].data;
        s_tkeep[k*KW +: KW] = q[k][0].keep;
        s_tlast[k]          = q[k][0].last;
      end else begin
        s_tdata[k*W +: W]   = '0;
        s_tkeep[k*KW +: KW] = '0;
        s_tlast[k]          = 1'b0;
      end
    end
    m_tready = rdy_mode ? ((cyc - rdy_base) % 3 == 0) : 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) sample();
    chk("rst_grant",  96'(grant),     96'(0));
    chk("rst_tready", 96'(s_tready),  96'(0));
    chk("rst_mvalid", 96'(m_tvalid),  96'(0));
    chk("rst_fcnt",   96'(frame_cnt), 96'(0));
    edge_drive();
    resetn = 1'b1;

    // Four simultaneous 3-beat frames, round-robin from port 0
    edge_drive();
    port_en = 4'hF;
    for (int p = 0; p < NP; p++) load(p, 1, 3);
    sample();
    chk("rr_c0_grant",  96'(grant),    96'(0));
    sample();
    chk("rr_c1_grant",  96'(grant),    96'(4'b0001));
    chk("rr_c1_tready", 96'(s_tready), 96'(4'b0001));
    sample();
    chk("rr_c2_beat", 96'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 96'({1'b1, mk(0, 1, 0, 3)}));
    wait_beats(12, "rr_beats");
    for (int i = 0; i < 12; i++) chk($sformatf("rr_beat%0d", i), 96'(cap[i]), 96'(mk(i/3, 1, i%3, 3)));
    chk("rr_back2back", 96'(cap_cyc[2] - cap_cyc[0]), 96'(2));
    for (int p = 1; p < NP; p++) chk($sformatf("rr_gap%0d", p), 96'(cap_cyc[p*3] - cap_cyc[p*3-1]), 96'(2));
    repeat (2) sample();
    chk("rr_fcnt", 96'(frame_cnt), 96'(4));

    // Disabled port 2 is not granted until enabled
    clear_cap();
    edge_drive();
    port_en = 4'b1011;
    load(2, 2, 3);
    repeat (4) sample();
    chk("dis_grant",  96'(grant),      96'(0));
    chk("dis_tready", 96'(s_tready),   96'(0));
    chk("dis_nobeat", 96'(cap.size()), 96'(0));
    edge_drive();
    port_en = 4'hF;
    sample();
    chk("en_c0_grant", 96'(grant), 96'(0));
    sample();
    chk("en_c1_grant", 96'(grant), 96'(4'b0100));
    sample();
    chk("en_c2_beat", 96'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 96'({1'b1, mk(2, 2, 0, 3)}));
    wait_beats(3, "en_beats");
    chk("en_last", 96'(cap[2]), 96'(mk(2, 2, 2, 3)));

    // Port 1 5-beat frame under 1,0,0 output ready pattern
    clear_cap();
    edge_drive();
    rdy_base = cyc;
    rdy_mode = 1'b1;
    load(1, 3, 5);
    wait_beats(5, "bp_beats");
    for (int b = 0; b < 5; b++) chk($sformatf("bp_beat%0d", b), 96'(cap[b]), 96'(mk(1, 3, b, 5)));
    chk("bp_stable",  96'(stall_err), 96'(0));
    chk("bp_tready0", 96'(saw_bp),    96'(1));
    edge_drive();
    rdy_mode = 1'b0;
    repeat (3) sample();
    chk("bp_fcnt",  96'(frame_cnt),  96'(6));
    chk("bp_count", 96'(cap.size()), 96'(5));

    // Enable dropped mid-frame: frame completes, next port-0 frame waits
    clear_cap();
    edge_drive();
    load(0, 4, 4);
    load(0, 5, 2);
    wait_beats(2, "en_drop_half");
    edge_drive();
    port_en = 4'b1110;
    wait_beats(4, "en_drop_beats");
    repeat (6) sample();
    chk("en_drop_count", 96'(cap.size()), 96'(4));
    chk("en_drop_grant", 96'(grant),      96'(0));
    for (int b = 0; b < 4; b++) chk($sformatf("en_drop_beat%0d", b), 96'(cap[b]), 96'(mk(0, 4, b, 4)));
    chk("en_drop_fcnt", 96'(frame_cnt), 96'(7));
    edge_drive();
    q[0].delete();
    port_en = 4'hF;
    repeat (2) sample();

    // Reset pulse during beat 3 of an 8-beat port-2 frame
    clear_cap();
    edge_drive();
    load(2, 6, 8);
    load(0, 7, 2);
    wait_beats(2, "mid_rst_pre");
    chk("mid_rst_gnt2", 96'(grant), 96'(4'b0100));
    edge_drive();
    resetn = 1'b0;
    edge_drive();
    resetn = 1'b1;
    sample();
    chk("mid_rst_grant",  96'(grant),     96'(0));
    chk("mid_rst_tready", 96'(s_tready),  96'(0));
    chk("mid_rst_mvalid", 96'(m_tvalid),  96'(0));
    chk("mid_rst_fcnt",   96'(frame_cnt), 96'(0));
    clear_cap();
    sample();
    chk("post_rst_grant", 96'(grant), 96'(4'b0001));
    wait_beats(2, "post_rst_beats");
    chk("post_rst_b0", 96'(cap[0]), 96'(mk(0, 7, 0, 2)));
    chk("post_rst_b1", 96'(cap[1]), 96'(mk(0, 7, 1, 2)));
    begin
      int t = 0;
      while (!(q[2].size() == 0 && !m_tvalid) && t < 100) begin
        sample();
        t++;
      end
    end
    chk("post_rst_drain", 96'(q[2].size() == 0 && !m_tvalid), 96'(1));
    repeat (2) sample();
    chk("post_rst_fcnt", 96'(frame_cnt), 96'(2));

    // Frame counter wrap
    edge_drive();
    force dut.frame_cnt = 32'hFFFF_FFFF;
    edge_drive();
    release dut.frame_cnt;
    sample();
    chk("wrap_pre", 96'(frame_cnt), 96'(32'hFFFF_FFFF));
    clear_cap();
    edge_drive();
    load(3, 8, 1);
    wait_beats(1, "wrap_beats");
    repeat (2) sample();
    chk("wrap_fcnt", 96'(frame_cnt), 96'(0));
    chk("wrap_beat", 96'(cap[0]),    96'(mk(3, 8, 0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
